// File: rtl/simmem_pkg.sv
// Shared constants and slot state encoding for the simulated-memory write-response path.
package simmem_pkg;

    localparam int unsigned DelayWidth                 = 8;
    localparam int unsigned WriteRespBankTotalCapacity = 16;
    localparam int unsigned WriteRespBankAddrWidth     = $clog2(WriteRespBankTotalCapacity);

    typedef enum logic [1:0] {
        SlotIdle       = 2'd0,
        SlotCounting   = 2'd1,
        SlotReleasable = 2'd2
    } delay_slot_state_e;

endpackage

// File: rtl/simmem_delay_slot.sv
// One bank slot: loads a delay, counts it down, then holds its release bit until the
// bank reports the response as sent.
module simmem_delay_slot
    import simmem_pkg::*;
#(
    parameter int unsigned DelayWidth = simmem_pkg::DelayWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic                  released_i,
    output logic                  idle_o,
    output logic                  release_en_o,
    output logic                  bad_release_o
);

    localparam logic [DelayWidth-1:0] CntOne = DelayWidth'(1);

    delay_slot_state_e     state, state_next;
    logic [DelayWidth-1:0] cnt, cnt_next;

    // State and counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= SlotIdle;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; COUNTING leaves on cnt==1 so the counter never wraps below 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            SlotIdle: begin
                if (load_i) begin
                    cnt_next   = delay_i;
                    state_next = (delay_i == '0) ? SlotReleasable : SlotCounting;
                end
            end
            SlotCounting: begin
                if (cnt == CntOne) begin
                    cnt_next   = '0;
                    state_next = SlotReleasable;
                end else begin
                    cnt_next = cnt - CntOne;
                end
            end
            SlotReleasable: begin
                if (released_i) begin
                    state_next = SlotIdle;
                end
            end
            default: begin
                state_next = SlotIdle;
                cnt_next   = '0;
            end
        endcase
    end

    assign idle_o        = (state == SlotIdle);
    assign release_en_o  = (state == SlotReleasable);
    assign bad_release_o = released_i && (state != SlotReleasable);

endmodule

// File: rtl/simmem_wresp_delay_releaser.sv
// Release-interface driver for the write-response bank: one delay slot per bank address,
// schedule address decode, pending-slot counter and registered bad-release flag.
module simmem_wresp_delay_releaser
    import simmem_pkg::*;
#(
    parameter int unsigned NumSlots   = simmem_pkg::WriteRespBankTotalCapacity,
    parameter int unsigned AddrWidth  = simmem_pkg::WriteRespBankAddrWidth,
    parameter int unsigned DelayWidth = simmem_pkg::DelayWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [AddrWidth-1:0]          sched_addr_i,
    input  logic [DelayWidth-1:0]         sched_delay_i,
    input  logic                          sched_valid_i,
    output logic                          sched_ready_o,
    input  logic [NumSlots-1:0]           released_addr_onehot_i,
    output logic [NumSlots-1:0]           release_en_o,
    output logic [$clog2(NumSlots+1)-1:0] num_pending_o,
    output logic                          err_o
);

    localparam int unsigned CntWidth = $clog2(NumSlots + 1);

    logic [NumSlots-1:0] idle;
    logic [NumSlots-1:0] bad_release;
    logic [NumSlots-1:0] load;
    logic                handshake;
    logic                valid_release;

    assign sched_ready_o = idle[sched_addr_i];
    assign handshake     = sched_valid_i && sched_ready_o;
    assign valid_release = |(released_addr_onehot_i & release_en_o);

    // Route an accepted schedule to the addressed slot only.
    always_comb begin
        load = '0;
        if (handshake) begin
            load[sched_addr_i] = 1'b1;
        end
    end

    for (genvar i = 0; i < NumSlots; i++) begin : g_slot
        simmem_delay_slot #(
            .DelayWidth(DelayWidth)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .load_i       (load[i]),
            .delay_i      (sched_delay_i),
            .released_i   (released_addr_onehot_i[i]),
            .idle_o       (idle[i]),
            .release_en_o (release_en_o[i]),
            .bad_release_o(bad_release[i])
        );
    end

    // Pending counter tracks non-idle slots; error flag is a one-cycle registered pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_pending_o <= '0;
            err_o         <= 1'b0;
        end else begin
            err_o <= |bad_release;
            case ({handshake, valid_release})
                2'b10:   num_pending_o <= num_pending_o + CntWidth'(1);
                2'b01:   num_pending_o <= num_pending_o - CntWidth'(1);
                default: num_pending_o <= num_pending_o;
            endcase
        end
    end

endmodule
